// File: rtl/keypoint_fetch_pkg.sv
// Shared constants, keypoint entry layout and FSM encoding for the keypoint
// fetch stage that sits between keypoint detect/filter and the descriptor stage.
`timescale 1ns/1ps
package keypoint_fetch_pkg;

    localparam int IMG_ROWS = 480;
    localparam int IMG_COLS = 640;
    localparam int MARGIN   = 8;
    localparam int KP_DEPTH = 2048;
    localparam int ADDR_W   = 11;
    localparam int CNT_W    = 12;

    // SRAM entry = {row[8:0], col[9:0]}
    localparam int ROW_W   = 9;
    localparam int COL_W   = 10;
    localparam int ENTRY_W = ROW_W + COL_W;
    localparam int ROW_MSB = 18;
    localparam int ROW_LSB = 10;
    localparam int COL_MSB = 9;
    localparam int COL_LSB = 0;

    // FIFO record = {idx, row, col}
    localparam int REC_W = ADDR_W + ENTRY_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/kp_skid_fifo.sv
// Two-entry registered FIFO holding kept keypoints; a push and a pop in the
// same cycle are both honoured.
`timescale 1ns/1ps
module kp_skid_fifo
    import keypoint_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [REC_W-1:0] din,
    input  logic             pop,
    output logic [REC_W-1:0] head,
    output logic [1:0]       occ
);

    logic [REC_W-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (occ != 2'd0);
    assign do_push = push && ((occ != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/keypoint_fetch.sv
// Reads the keypoint list back from SRAM in order, drops entries inside the
// border margin and streams survivors to the descriptor stage.
`timescale 1ns/1ps
module keypoint_fetch
    import keypoint_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] kp_count,
    output logic        busy,
    output logic        done,
    output logic        kp_re,
    output logic [10:0] kp_addr,
    input  logic [18:0] kp_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  out_row,
    output logic [9:0]  out_col,
    output logic [10:0] out_idx,
    output logic [11:0] drop_count
);

    // Output handshake: a record transfers on every cycle where out_valid and
    // out_ready are both high; while out_valid && !out_ready the head is held.

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [CNT_W-1:0]  n_len;
    logic [CNT_W-1:0]  issue_cnt;
    logic              inflight;
    logic [ADDR_W-1:0] ret_idx;
    logic              pop;
    logic              issue;
    logic              last_issue;
    logic              keep;
    logic [2:0]        pending;
    logic [1:0]        occ;
    logic [REC_W-1:0]  head;
    logic [ROW_W-1:0]  kp_row;
    logic [COL_W-1:0]  kp_col;

    assign pop = out_valid && out_ready;

    // Slots already committed after this cycle's pop; at most one more read may
    // be launched so the two FIFO entries can never be oversubscribed.
    assign pending    = 3'(occ) + 3'(inflight) - 3'(pop);
    assign issue      = (state == ST_FETCH) && (pending <= 3'd1);
    assign last_issue = issue && (issue_cnt == n_len - 12'd1);

    assign kp_row = kp_dout[ROW_MSB:ROW_LSB];
    assign kp_col = kp_dout[COL_MSB:COL_LSB];
    assign keep   = inflight
                 && (kp_row >= ROW_W'(MARGIN)) && (kp_row < ROW_W'(IMG_ROWS - MARGIN))
                 && (kp_col >= COL_W'(MARGIN)) && (kp_col < COL_W'(IMG_COLS - MARGIN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = (kp_count == '0) ? ST_FIN : ST_FETCH;
            ST_FETCH: if (last_issue) state_next = ST_DRAIN;
            ST_DRAIN: if ((occ == 2'd0) && !inflight) state_next = ST_FIN;
            ST_FIN:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        kp_re   = issue;
        kp_addr = issue ? issue_cnt[ADDR_W-1:0] : '0;
        busy    = (state == ST_FETCH) || (state == ST_DRAIN);
        done    = (state == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_len      <= '0;
            issue_cnt  <= '0;
            inflight   <= 1'b0;
            ret_idx    <= '0;
            drop_count <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                ret_idx   <= issue_cnt[ADDR_W-1:0];
                issue_cnt <= issue_cnt + 12'd1;
            end
            if ((state == ST_IDLE) && start) begin
                n_len      <= (kp_count > CNT_W'(KP_DEPTH)) ? CNT_W'(KP_DEPTH) : kp_count;
                issue_cnt  <= '0;
                drop_count <= '0;
            end else if (inflight && !keep && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + 12'd1;
            end
        end
    end

    kp_skid_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep),
        .din   ({ret_idx, kp_dout}),
        .pop   (pop),
        .head  (head),
        .occ   (occ)
    );

    assign out_valid = (occ != 2'd0);
    assign out_idx   = head[REC_W-1:ENTRY_W];
    assign out_row   = head[ROW_MSB:ROW_LSB];
    assign out_col   = head[COL_MSB:COL_LSB];

endmodule

// File: tb/tb_keypoint_fetch.sv
// Directed bench for keypoint_fetch: SRAM model, per-cycle scoreboard and
// table-driven border vectors with hand-computed keep/drop outcomes.
`timescale 1ns/1ps
module tb_keypoint_fetch;

    typedef struct {
        logic [8:0] row;
        logic [9:0] col;
        logic       keep;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] kp_count;
    logic        busy;
    logic        done;
    logic        kp_re;
    logic [10:0] kp_addr;
    logic [18:0] kp_dout;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_row;
    logic [9:0]  out_col;
    logic [10:0] out_idx;
    logic [11:0] drop_count;

    int total = 0;
    int bad   = 0;

    logic [29:0] exp_q[$];
    logic [18:0] sram [2048];
    vec_t        tab [12];

    int          exp_addr;
    int          reads;
    int          acc_cnt;
    int          first_acc;
    int          last_acc;
    int          max_occ;
    int          busy_cnt;
    logic        ovf;
    logic        prev_valid;
    logic        prev_ready;
    logic [29:0] prev_head;

    keypoint_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .kp_count   (kp_count),
        .busy       (busy),
        .done       (done),
        .kp_re      (kp_re),
        .kp_addr    (kp_addr),
        .kp_dout    (kp_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_idx    (out_idx),
        .drop_count (drop_count)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (kp_re) kp_dout <= sram[kp_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ready_pat(input int mode, input int k);
        if (mode == 0) return 1'b1;
        return ((k % 4) == 0) || ((k % 4) == 3);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_kp_re"}, 32'(kp_re), 0);
        check({tag, "_addr"},  32'(kp_addr), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_row"},   32'(out_row), 0);
        check({tag, "_col"},   32'(out_col), 0);
        check({tag, "_idx"},   32'(out_idx), 0);
        check({tag, "_drops"}, 32'(drop_count), 0);
    endtask

    // per-cycle scoreboard and protocol checks, called at the falling edge
    task automatic check_cycle(input int k);
        logic [29:0] exp;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_output: got idx %0d row %0d col %0d, expected none", out_idx, out_row, out_col);
            end else begin
                exp = exp_q.pop_front();
                check("out_record", {2'b0, out_idx, out_row, out_col}, {2'b0, exp});
            end
            if (first_acc < 0) first_acc = k;
            last_acc = k;
            acc_cnt++;
        end
        if (prev_valid && !prev_ready) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_hold", {2'b0, out_idx, out_row, out_col}, {2'b0, prev_head});
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_head  = {out_idx, out_row, out_col};
        if (kp_re) begin
            check("rd_addr", 32'(kp_addr), 32'(exp_addr));
            exp_addr++;
            reads++;
        end
        if (int'(dut.u_fifo.occ) > max_occ) max_occ = int'(dut.u_fifo.occ);
        if (dut.u_fifo.push && (dut.u_fifo.occ == 2'd2) && !(out_valid && out_ready)) ovf = 1'b1;
        if (busy) busy_cnt++;
    endtask

    // driver: start pulse, then step until done or budget expires
    task automatic run_list(input int cnt, input int mode, input int budget,
                            input int rst_at, input int repulse, output int lat);
        lat = -1;
        exp_addr = 0; reads = 0; acc_cnt = 0; first_acc = -1; last_acc = -1;
        max_occ = 0; busy_cnt = 0; ovf = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
        @(posedge clk); #1;
        kp_count  = 12'(cnt);
        start     = 1'b1;
        out_ready = ready_pat(mode, 0);
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            start = (repulse != 0) && (k == 3);
            if (start) kp_count = 12'd1;
            out_ready = ready_pat(mode, k);
            @(negedge clk);
            if (!rst_n) begin
                check_all_zero("mid_reset");
                rst_n = 1'b1;
                exp_q.delete();
                return;
            end
            check_cycle(k);
            if (done) begin
                lat = k;
                break;
            end
            if ((rst_at != 0) && (acc_cnt == rst_at)) rst_n = 1'b0;
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
            return;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        check("busy_after", 32'(busy), 0);
        check("fifo_occ_max", 32'(max_occ <= 2), 1);
        check("fifo_overflow", 32'(ovf), 0);
        check("missing_outputs", 32'(exp_q.size()), 0);
    endtask

    task automatic load_interior(input int n);
        for (int i = 0; i < n; i++) begin
            sram[i] = {9'(8 + (i % 400)), 10'(8 + (i % 600))};
            exp_q.push_back({11'(i), 9'(8 + (i % 400)), 10'(8 + (i % 600))});
        end
    endtask

    initial begin
        int lat;

        tab[0]  = '{9'd8,   10'd8,    1'b1};
        tab[1]  = '{9'd7,   10'd100,  1'b0};
        tab[2]  = '{9'd471, 10'd631,  1'b1};
        tab[3]  = '{9'd472, 10'd100,  1'b0};
        tab[4]  = '{9'd100, 10'd632,  1'b0};
        tab[5]  = '{9'd100, 10'd7,    1'b0};
        tab[6]  = '{9'd8,   10'd631,  1'b1};
        tab[7]  = '{9'd479, 10'd639,  1'b0};
        tab[8]  = '{9'd511, 10'd1023, 1'b0};
        tab[9]  = '{9'd200, 10'd0,    1'b0};
        tab[10] = '{9'd0,   10'd0,    1'b0};
        tab[11] = '{9'd300, 10'd400,  1'b1};

        for (int i = 0; i < 2048; i++) sram[i] = '0;
        rst_n = 1'b0; start = 1'b0; kp_count = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // empty list: straight to FIN
        run_list(0, 0, 20, 0, 0, lat);
        check("cnt0_latency", 32'(lat), 1);
        check("cnt0_reads", 32'(reads), 0);
        check("cnt0_outputs", 32'(acc_cnt), 0);
        check("cnt0_busy", 32'(busy_cnt), 0);
        check("cnt0_drops", 32'(drop_count), 0);

        // four entries, two kept (idx0 and idx3: row 471 < 472)
        sram[0] = {9'd100, 10'd200};
        sram[1] = {9'd3,   10'd50};
        sram[2] = {9'd240, 10'd636};
        sram[3] = {9'd471, 10'd320};
        exp_q.push_back({11'd0, 9'd100, 10'd200});
        exp_q.push_back({11'd3, 9'd471, 10'd320});
        run_list(4, 0, 40, 0, 0, lat);
        check("cnt4_latency", 32'(lat), 8);
        check("cnt4_first_out", 32'(first_acc), 3);
        check("cnt4_reads", 32'(reads), 4);
        check("cnt4_drops", 32'(drop_count), 2);
        check("cnt4_busy", 32'(busy_cnt), 7);

        // border table
        for (int i = 0; i < 12; i++) begin
            sram[i] = {tab[i].row, tab[i].col};
            if (tab[i].keep) exp_q.push_back({11'(i), tab[i].row, tab[i].col});
        end
        run_list(12, 0, 60, 0, 0, lat);
        check("table_latency", 32'(lat), 16);
        check("table_outputs", 32'(acc_cnt), 4);
        check("table_drops", 32'(drop_count), 8);

        // 16 interior at full rate; a second start mid-run must be ignored
        load_interior(16);
        run_list(16, 0, 60, 0, 1, lat);
        check("full_latency", 32'(lat), 20);
        check("full_first_out", 32'(first_acc), 3);
        check("full_last_out", 32'(last_acc), 18);
        check("full_outputs", 32'(acc_cnt), 16);
        check("full_drops", 32'(drop_count), 0);

        // same list under back-pressure 1,0,0,1
        load_interior(16);
        run_list(16, 1, 200, 0, 0, lat);
        check("bp_done_seen", 32'(lat > 0), 1);
        check("bp_outputs", 32'(acc_cnt), 16);

        // oversized count clamps to KP_DEPTH
        load_interior(2048);
        run_list(3000, 0, 2200, 0, 0, lat);
        check("clamp_latency", 32'(lat), 2052);
        check("clamp_reads", 32'(reads), 2048);
        check("clamp_outputs", 32'(acc_cnt), 2048);

        // reset at the 5th output, then a clean rerun
        load_interior(16);
        run_list(16, 0, 60, 5, 0, lat);
        check("rst_no_done", 32'(lat), 32'(-1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("post_rst_done", 32'(done), 0);
            check("post_rst_kp_re", 32'(kp_re), 0);
        end
        load_interior(16);
        run_list(16, 0, 60, 0, 0, lat);
        check("rerun_latency", 32'(lat), 20);
        check("rerun_outputs", 32'(acc_cnt), 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
